// File: rtl/risc16_pkg.sv
// Shared RiSC-16 decode definitions: opcodes, ALU function codes, field positions.
// Consumed by the decode stage and by the execute-side RiSC16_alu.
package risc16_pkg;

    localparam int ALU_FUNCT_LEN = 2;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 13;
    localparam int RA_HI  = 12;
    localparam int RA_LO  = 10;
    localparam int RB_HI  = 9;
    localparam int RB_LO  = 7;
    localparam int RC_HI  = 2;
    localparam int RC_LO  = 0;
    localparam int IMM7_HI  = 6;
    localparam int IMM10_HI = 9;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_ADDI = 3'd1,
        OP_NAND = 3'd2,
        OP_LUI  = 3'd3,
        OP_SW   = 3'd4,
        OP_LW   = 3'd5,
        OP_BEQ  = 3'd6,
        OP_JALR = 3'd7
    } opcode_t;

    typedef enum logic [ALU_FUNCT_LEN-1:0] {
        ALU_ADD   = 2'd0,
        ALU_NAND  = 2'd1,
        ALU_PASSA = 2'd2,
        ALU_SUB   = 2'd3
    } aluFunct_t;

    typedef enum logic [1:0] {
        A_RB  = 2'd0,
        A_RA  = 2'd1,
        A_LUI = 2'd2
    } aSel_t;

    typedef enum logic [1:0] {
        B_RC   = 2'd0,
        B_RB   = 2'd1,
        B_IMM  = 2'd2,
        B_ZERO = 2'd3
    } bSel_t;

    typedef struct packed {
        aluFunct_t funct;
        aSel_t     aSel;
        bSel_t     bSel;
        logic      writes;
        logic      isStore;
    } ctrl_t;

    function automatic ctrl_t decodeOp(input opcode_t op);
        ctrl_t c;
        c = '{funct: ALU_ADD, aSel: A_RB, bSel: B_RC, writes: 1'b0, isStore: 1'b0};
        unique case (1'b1)
            op == OP_ADD:  c = '{ALU_ADD,   A_RB,  B_RC,   1'b1, 1'b0};
            op == OP_ADDI: c = '{ALU_ADD,   A_RB,  B_IMM,  1'b1, 1'b0};
            op == OP_NAND: c = '{ALU_NAND,  A_RB,  B_RC,   1'b1, 1'b0};
            op == OP_LUI:  c = '{ALU_PASSA, A_LUI, B_ZERO, 1'b1, 1'b0};
            op == OP_SW:   c = '{ALU_ADD,   A_RB,  B_IMM,  1'b0, 1'b1};
            op == OP_LW:   c = '{ALU_ADD,   A_RB,  B_IMM,  1'b1, 1'b0};
            op == OP_BEQ:  c = '{ALU_SUB,   A_RA,  B_RB,   1'b0, 1'b0};
            op == OP_JALR: c = '{ALU_PASSA, A_RB,  B_ZERO, 1'b1, 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/risc16_regfile.sv
// RiSC-16 architectural register file: three async read ports, one sync write port.
// r0 is hardwired to zero; synchronous active-low clear.
module risc16_regfile #(
    parameter int WORD_LENGTH  = 16,
    parameter int REG_ADDR_LEN = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [REG_ADDR_LEN-1:0] rdAddrA,
    input  logic [REG_ADDR_LEN-1:0] rdAddrB,
    input  logic [REG_ADDR_LEN-1:0] rdAddrC,
    output logic [WORD_LENGTH-1:0]  rdDataA,
    output logic [WORD_LENGTH-1:0]  rdDataB,
    output logic [WORD_LENGTH-1:0]  rdDataC,
    input  logic                    wrEn,
    input  logic [REG_ADDR_LEN-1:0] wrAddr,
    input  logic [WORD_LENGTH-1:0]  wrData
);

    localparam int DEPTH = 1 << REG_ADDR_LEN;

    logic [WORD_LENGTH-1:0] regs [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wrEn && wrAddr != '0) begin
            regs[wrAddr] <= wrData;
        end
    end

    assign rdDataA = (rdAddrA == '0) ? '0 : regs[rdAddrA];
    assign rdDataB = (rdAddrB == '0) ? '0 : regs[rdAddrB];
    assign rdDataC = (rdAddrC == '0) ? '0 : regs[rdAddrC];

endmodule

// File: rtl/risc16_decode_stage.sv
// RiSC-16 decode/issue stage: decodes, reads the register file, registers ALU operands.
// Define RISC16_WB_BYPASS_EN to forward same-cycle writeback data into the operands.
module risc16_decode_stage
    import risc16_pkg::*;
#(
    parameter int WORD_LENGTH  = 16,
    parameter int REG_ADDR_LEN = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     if_valid,
    output logic                     if_ready,
    input  logic [WORD_LENGTH-1:0]   if_instr,
    input  logic [WORD_LENGTH-1:0]   if_pc,
    input  logic                     flush,
    output logic                     ex_valid,
    input  logic                     ex_ready,
    output logic [WORD_LENGTH-1:0]   ex_srcA,
    output logic [WORD_LENGTH-1:0]   ex_srcB,
    output logic [ALU_FUNCT_LEN-1:0] ex_funct,
    output logic [2:0]               ex_opcode,
    output logic [REG_ADDR_LEN-1:0]  ex_dest,
    output logic                     ex_wen,
    output logic [WORD_LENGTH-1:0]   ex_store_data,
    output logic [WORD_LENGTH-1:0]   ex_imm,
    output logic [WORD_LENGTH-1:0]   ex_pc,
    input  logic                     wb_en,
    input  logic [REG_ADDR_LEN-1:0]  wb_addr,
    input  logic [WORD_LENGTH-1:0]   wb_data
);

    logic [REG_ADDR_LEN-1:0] rA, rB, rC;
    logic [WORD_LENGTH-1:0]  rdA, rdB, rdC;
    logic [WORD_LENGTH-1:0]  opA, opB, opC;
    logic [WORD_LENGTH-1:0]  immExt, luiVal;
    logic [WORD_LENGTH-1:0]  srcA, srcB;
    logic [2:0]              opcode;
    ctrl_t                   ctrl;
    logic                    exValid;

    assign opcode = if_instr[OP_HI:OP_LO];
    assign rA     = if_instr[RA_HI:RA_LO];
    assign rB     = if_instr[RB_HI:RB_LO];
    assign rC     = if_instr[RC_HI:RC_LO];
    assign immExt = {{(WORD_LENGTH-7){if_instr[IMM7_HI]}}, if_instr[IMM7_HI:0]};
    assign luiVal = WORD_LENGTH'({if_instr[IMM10_HI:0], 6'b0});
    assign ctrl   = decodeOp(opcode_t'(opcode));

    risc16_regfile #(
        .WORD_LENGTH (WORD_LENGTH),
        .REG_ADDR_LEN(REG_ADDR_LEN)
    ) uRegfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .rdAddrA(rA),
        .rdAddrB(rB),
        .rdAddrC(rC),
        .rdDataA(rdA),
        .rdDataB(rdB),
        .rdDataC(rdC),
        .wrEn   (wb_en),
        .wrAddr (wb_addr),
        .wrData (wb_data)
    );

`ifdef RISC16_WB_BYPASS_EN
    assign opA = (wb_en && wb_addr == rA && rA != '0) ? wb_data : rdA;
    assign opB = (wb_en && wb_addr == rB && rB != '0) ? wb_data : rdB;
    assign opC = (wb_en && wb_addr == rC && rC != '0) ? wb_data : rdC;
`else
    assign opA = rdA;
    assign opB = rdB;
    assign opC = rdC;
`endif

    always_comb begin
        srcA = '0;
        unique case (ctrl.aSel)
            A_RB:    srcA = opB;
            A_RA:    srcA = opA;
            A_LUI:   srcA = luiVal;
            default: srcA = '0;
        endcase
    end

    always_comb begin
        srcB = '0;
        unique case (ctrl.bSel)
            B_RC:    srcB = opC;
            B_RB:    srcB = opB;
            B_IMM:   srcB = immExt;
            default: srcB = '0;
        endcase
    end

    assign if_ready = !exValid || ex_ready;
    assign ex_valid = exValid;

    // Flush outranks capture; a stalled issue register keeps every field.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exValid       <= 1'b0;
            ex_srcA       <= '0;
            ex_srcB       <= '0;
            ex_funct      <= '0;
            ex_opcode     <= '0;
            ex_dest       <= '0;
            ex_wen        <= 1'b0;
            ex_store_data <= '0;
            ex_imm        <= '0;
            ex_pc         <= '0;
        end else if (flush) begin
            exValid <= 1'b0;
        end else if (if_ready) begin
            exValid <= if_valid;
            if (if_valid) begin
                ex_srcA       <= srcA;
                ex_srcB       <= srcB;
                ex_funct      <= ctrl.funct;
                ex_opcode     <= opcode;
                ex_dest       <= rA;
                ex_wen        <= ctrl.writes && (rA != '0);
                ex_store_data <= ctrl.isStore ? opA : '0;
                ex_imm        <= immExt;
                ex_pc         <= if_pc;
            end
        end
    end

endmodule

// File: tb/tb_risc16_decode_stage.sv
// Self-checking bench for risc16_decode_stage: directed table, corner sequences,
// and random traffic against an instruction-level reference model.
module tb_risc16_decode_stage;
    import risc16_pkg::*;

`ifdef RISC16_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, if_valid, if_ready, flush, ex_valid, ex_ready;
    logic [15:0] if_instr, if_pc, ex_srcA, ex_srcB, ex_store_data, ex_imm, ex_pc;
    logic [1:0]  ex_funct;
    logic [2:0]  ex_opcode, ex_dest, wb_addr;
    logic        ex_wen, wb_en;
    logic [15:0] wb_data;

    always #5 clk = ~clk;

    risc16_decode_stage dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_srcA(ex_srcA), .ex_srcB(ex_srcB), .ex_funct(ex_funct),
        .ex_opcode(ex_opcode), .ex_dest(ex_dest), .ex_wen(ex_wen),
        .ex_store_data(ex_store_data), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    typedef struct packed {
        logic        vld;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  f;
        logic [2:0]  op;
        logic [2:0]  dest;
        logic        wen;
        logic [15:0] sd;
        logic [15:0] imm;
        logic [15:0] pc;
    } out_t;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  f;
        logic [2:0]  dest;
        logic        wen;
        logic [15:0] imm;
        logic [15:0] sd;
    } vec_t;

    out_t        mdl;
    logic [15:0] rf [8];
    int          errors = 0;
    int          checks = 0;

    function automatic out_t actual();
        return {ex_valid, ex_srcA, ex_srcB, ex_funct, ex_opcode, ex_dest,
                ex_wen, ex_store_data, ex_imm, ex_pc};
    endfunction

    // Architectural read as seen by an instruction in decode this cycle.
    function automatic logic [15:0] rd(input int i);
        if (i == 0) return 16'h0;
        if (BYP && wb_en && int'(wb_addr) == i) return wb_data;
        return rf[i];
    endfunction

    function automatic out_t dec(input logic [15:0] ins, input logic [15:0] pc);
        out_t o;
        int   op, ra, rb, rc, sv, lui;
        op  = int'(ins[15:13]);
        ra  = int'(ins[12:10]);
        rb  = int'(ins[9:7]);
        rc  = int'(ins[2:0]);
        sv  = int'(ins[6:0]);
        if (sv >= 64) sv = sv - 128;
        lui = int'(ins[9:0]) * 64;
        o      = '0;
        o.vld  = 1'b1;
        o.op   = ins[15:13];
        o.dest = ins[12:10];
        o.imm  = sv[15:0];
        o.pc   = pc;
        case (op)
            0: begin o.a = rd(rb); o.b = rd(rc); o.f = ALU_ADD; o.wen = 1; end
            1: begin o.a = rd(rb); o.b = sv[15:0]; o.f = ALU_ADD; o.wen = 1; end
            2: begin o.a = rd(rb); o.b = rd(rc); o.f = ALU_NAND; o.wen = 1; end
            3: begin o.a = lui[15:0]; o.b = 0; o.f = ALU_PASSA; o.wen = 1; end
            4: begin o.a = rd(rb); o.b = sv[15:0]; o.f = ALU_ADD; o.sd = rd(ra); end
            5: begin o.a = rd(rb); o.b = sv[15:0]; o.f = ALU_ADD; o.wen = 1; end
            6: begin o.a = rd(ra); o.b = rd(rb); o.f = ALU_SUB; end
            default: begin o.a = rd(rb); o.b = 0; o.f = ALU_PASSA; o.wen = 1; end
        endcase
        if (ra == 0) o.wen = 1'b0;
        return o;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        out_t        nxt;
        logic [15:0] nrf [8];
        nxt = mdl;
        nrf = rf;
        if (!rst_n) begin
            nxt = '0;
            for (int i = 0; i < 8; i++) nrf[i] = 16'h0;
        end else begin
            if (wb_en && wb_addr != 0) nrf[wb_addr] = wb_data;
            if (flush) nxt.vld = 1'b0;
            else if (!mdl.vld || ex_ready) begin
                if (if_valid) nxt = dec(if_instr, if_pc);
                else nxt.vld = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        mdl = nxt;
        rf  = nrf;
        chk("model_outputs", actual(), mdl);
        chk("model_if_ready", if_ready, !mdl.vld || ex_ready);
    endtask

    task automatic wbWrite(input logic [2:0] addr, input logic [15:0] data);
        if_valid = 0;
        wb_en    = 1;
        wb_addr  = addr;
        wb_data  = data;
        tick();
        wb_en    = 0;
    endtask

    vec_t vecs [8];
    out_t snap;

    initial begin
        vecs[0] = '{16'h2405, 16'h0000, 16'h0005, ALU_ADD,   3'd1, 1'b1, 16'h0005, 16'h0};
        vecs[1] = '{16'h0C82, 16'h0003, 16'h0004, ALU_ADD,   3'd3, 1'b1, 16'h0002, 16'h0};
        vecs[2] = '{16'h6BFF, 16'hFFC0, 16'h0000, ALU_PASSA, 3'd2, 1'b1, 16'hFFFF, 16'h0};
        vecs[3] = '{16'h4502, 16'h0004, 16'h0004, ALU_NAND,  3'd1, 1'b1, 16'h0002, 16'h0};
        vecs[4] = '{16'h8883, 16'h0003, 16'h0003, ALU_ADD,   3'd2, 1'b0, 16'h0003, 16'h4};
        vecs[5] = '{16'hA0FE, 16'h0003, 16'hFFFE, ALU_ADD,   3'd0, 1'b0, 16'hFFFE, 16'h0};
        vecs[6] = '{16'hC57F, 16'h0003, 16'h0004, ALU_SUB,   3'd1, 1'b0, 16'hFFFF, 16'h0};
        vecs[7] = '{16'hFD00, 16'h0004, 16'h0000, ALU_PASSA, 3'd7, 1'b1, 16'h0000, 16'h0};

        mdl = '0;
        for (int i = 0; i < 8; i++) rf[i] = 16'h0;
        rst_n = 0; if_valid = 0; if_instr = 0; if_pc = 0; flush = 0;
        ex_ready = 1; wb_en = 0; wb_addr = 0; wb_data = 0;

        // Reset
        tick();
        tick();
        rst_n = 1;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_if_ready", if_ready, 1);
        chk("rst_ex_data", actual(), 0);

        // R[1..7] clear after reset
        for (int i = 1; i < 8; i++) begin
            logic [2:0] r;
            r = 3'(i);
            if_valid = 1;
            if_instr = {3'b000, 3'd1, r, 4'b0000, r};
            tick();
            chk("rst_reg_read", {ex_srcA, ex_srcB}, 0);
        end

        if_valid = 0;
        tick();
        wbWrite(3'd1, 16'd3);
        wbWrite(3'd2, 16'd4);

        // Decode table
        for (int i = 0; i < 8; i++) begin
            if_valid = 1;
            ex_ready = 1;
            if_instr = vecs[i].instr;
            if_pc    = 16'h0100 + 16'(i);
            tick();
            chk("vec_valid", ex_valid, 1);
            chk("vec_srcA", ex_srcA, vecs[i].a);
            chk("vec_srcB", ex_srcB, vecs[i].b);
            chk("vec_funct", ex_funct, vecs[i].f);
            chk("vec_dest", ex_dest, vecs[i].dest);
            chk("vec_wen", ex_wen, vecs[i].wen);
            chk("vec_imm", ex_imm, vecs[i].imm);
            chk("vec_store", ex_store_data, vecs[i].sd);
            chk("vec_opcode", ex_opcode, vecs[i].instr[15:13]);
            chk("vec_pc", ex_pc, 16'h0100 + 16'(i));
        end

        // Stall: BEQ held for 3 cycles, then a single transfer
        if_valid = 0;
        ex_ready = 1;
        tick();
        if_valid = 1;
        if_instr = 16'hC57F;
        if_pc    = 16'h0200;
        ex_ready = 0;
        tick();
        snap = actual();
        chk("stall_funct", ex_funct, ALU_SUB);
        chk("stall_imm", ex_imm, 16'hFFFF);
        chk("stall_srcs", {ex_srcA, ex_srcB}, {16'd3, 16'd4});
        if_instr = 16'h2405;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", actual(), snap);
            chk("stall_if_ready", if_ready, 0);
        end
        if_valid = 0;
        ex_ready = 1;
        tick();
        chk("stall_release", ex_valid, 0);

        // Flush, with a dropped write to r0
        if_valid = 1;
        if_instr = 16'h2405;
        tick();
        flush    = 1;
        if_instr = 16'h0C82;
        wb_en    = 1;
        wb_addr  = 0;
        wb_data  = 16'hBEEF;
        tick();
        chk("flush_valid", ex_valid, 0);
        chk("flush_if_ready", if_ready, 1);
        flush    = 0;
        wb_en    = 0;
        if_instr = 16'h0400;
        tick();
        chk("r0_zero", {ex_srcA, ex_srcB}, 0);

        // Same-cycle writeback to a source register
        wb_en    = 1;
        wb_addr  = 1;
        wb_data  = 16'h1234;
        if_instr = 16'h0C82;
        tick();
        chk("wb_same_cycle", ex_srcA, BYP ? 16'h1234 : 16'h0003);
        chk("wb_same_cycle_b", ex_srcB, 16'h0004);
        wb_en = 0;
        tick();
        chk("wb_after", ex_srcA, 16'h1234);

        // Mid-operation reset drops the held op and beats a write
        ex_ready = 0;
        if_instr = 16'h0C82;
        tick();
        rst_n   = 0;
        wb_en   = 1;
        wb_addr = 5;
        wb_data = 16'h5555;
        tick();
        chk("midrst_valid", ex_valid, 0);
        chk("midrst_data", actual(), 0);
        rst_n    = 1;
        wb_en    = 0;
        ex_ready = 1;
        if_instr = {3'b000, 3'd1, 3'd5, 4'b0000, 3'd1};
        tick();
        chk("midrst_regs", {ex_srcA, ex_srcB}, 0);

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            rst_n    = ($urandom_range(0, 99) != 0);
            flush    = ($urandom_range(0, 9) == 0);
            if_valid = ($urandom_range(0, 3) != 0);
            ex_ready = ($urandom_range(0, 3) != 0);
            if_instr = 16'($urandom);
            if_pc    = 16'($urandom);
            wb_en    = ($urandom_range(0, 1) != 0);
            wb_addr  = 3'($urandom);
            wb_data  = 16'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
